uart_rx_intr: RTL and testbench
===============================

Name: uart_rx_intr

Overview:
- Serial UART receiver that feeds the CPU core's `rx_data` and `irr` inputs and consumes its `ack` output.
- Deserialises 8N1 frames from the `rx` pin and latches each good byte into a holding register.
- Raises a level interrupt request that stays high until the CPU acknowledges it.
- Sits between the board RX pin and the CPU, mirroring the existing TX path.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per serial bit (100 MHz / 115200); must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2, cycles from start-edge detection to the start-bit mid-sample.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line, idle high
- rx_data  output  8  last good received byte
- irr  output  1  interrupt request; level, held until ack
- ack  input  1  interrupt acknowledge from CPU; level, may be held several cycles
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  one-cycle pulse: good byte completed while irr already high

Behaviour:
- Reset: all outputs go to 0. `rx_data` = 8'h00. Synchroniser flops = 1. FSM = IDLE. Counters = 0. Reset mid-frame aborts the frame with no output pulses.
- Sync: `rx` passes through a 2-flop synchroniser to give `rx_s`. All decisions use `rx_s`; `rx` is never used directly.
- Baud counter: width $clog2(CLKS_PER_BIT). Reloaded to 0 on every state entry.
- IDLE: when `rx_s` = 0, go to START with count = 0.
- START: count up. At count == HALF_BIT-1, sample `rx_s`:
  - 0: go to DATA, bit index = 0, count = 0.
  - 1: glitch; go back to IDLE with no outputs.
- DATA: at count == CLKS_PER_BIT-1, sample `rx_s` into shift[bit index] (LSB first) and reset count.
  - After bit index 7 is sampled, go to STOP.
- STOP: at count == CLKS_PER_BIT-1, sample `rx_s`:
  - 1 (good): `rx_data` <= shift; `irr` <= 1; if `irr` was already 1, pulse `overrun`. Go to IDLE.
  - 0 (bad): pulse `frame_err`; `rx_data` and `irr` unchanged; shift discarded. Go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s` = 1, then go to IDLE. A break condition never produces repeated frames.
- Latency: `irr` and `rx_data` update on the clock edge after the stop-bit mid-sample. That is about 9.5 bit times + 3 cycles after the `rx` falling edge.
- Interrupt handshake:
  - `irr` clears on any cycle with `ack` = 1 and no simultaneous good-byte completion.
  - If completion and `ack` coincide, `irr` stays 1 (set wins), `rx_data` takes the new byte, and no `overrun` pulse.
  - `ack` while `irr` = 0 has no effect.
  - `rx_data` is stable while `irr` = 1, except on overrun (newest byte wins).
- Receive continues independently of `irr` and `ack`; the block never stalls the line.
- Back-to-back frames: a start bit beginning directly after the stop bit mid-sample must be caught. IDLE is re-entered within 1 cycle of the stop sample.
- `frame_err` and `overrun` are never asserted in the same cycle.

Test Plan (CLKS_PER_BIT=16):
- Reset, then send 8'hA5 at 16 clk/bit -> `rx_data` = 8'hA5 and `irr` = 1 the cycle after the stop mid-sample; `frame_err` = `overrun` = 0. Hold `ack` 2 cycles -> `irr` = 0 after the first ack cycle, `rx_data` still 8'hA5.
- Drive an 8-cycle low glitch on `rx` -> FSM returns to IDLE; `irr`, `frame_err`, `rx_data` unchanged. A following 8'h3C frame -> `rx_data` = 8'h3C.
- Send 8'h55 with stop bit forced low, then hold `rx` low 40 cycles, then high -> one `frame_err` pulse; `irr` stays 0; no further events until `rx` returns high. Next 8'h0F -> received correctly.
- Send 8'h11 then 8'h22 back-to-back with no ack -> `irr` = 1 throughout; one `overrun` pulse at the second stop sample; `rx_data` = 8'h22.
- Assert `ack` exactly on the completion cycle of 8'h7E while `irr` = 1 -> `irr` stays 1, `rx_data` = 8'h7E, no `overrun`.
- Assert `reset` mid-DATA of 8'hFF, release, send 8'h81 -> no outputs for the aborted frame; `rx_data` = 8'h81, `irr` = 1.

Source files
------------

// File: rtl/uart_rx_intr_if.sv
// Bus bundle between the UART receiver and the CPU core: serial line in,
// received byte and interrupt request out, acknowledge back in.
interface uart_rx_intr_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       irr;
  logic       ack;
  logic       frame_err;
  logic       overrun;

  // CPU/board side drives the line and the acknowledge
  modport master (
    output rx,
    output ack,
    input  rx_data,
    input  irr,
    input  frame_err,
    input  overrun
  );

  // Receiver side
  modport slave (
    input  rx,
    input  ack,
    output rx_data,
    output irr,
    output frame_err,
    output overrun
  );
endinterface

// File: rtl/uart_rx_intr.sv
// 8N1 UART receiver with a byte holding register and a level interrupt
// request that stays up until the CPU acknowledges it. The line is sampled
// at bit centres, found by counting half a bit from the start edge.
module uart_rx_intr #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input logic           clk,
  input logic           reset,
  uart_rx_intr_if.slave bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_meta;
  logic          rx_s;
  logic [7:0]    rx_data;
  logic          irr;
  logic          frame_err;
  logic          overrun;

  assign bus.rx_data   = rx_data;
  assign bus.irr       = irr;
  assign bus.frame_err = frame_err;
  assign bus.overrun   = overrun;

  // Two-flop synchroniser; resets to the idle-high line level
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM plus interrupt handshake; a good-byte completion beats a coincident ack
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_data   <= 8'h00;
      irr       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (bus.ack) begin
        irr <= 1'b0;
      end

      case (state)
        IDLE: begin
          count <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (count == CW'(HALF_BIT - 1)) begin
            count   <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            count <= count + CW'(1);
          end
        end

        DATA: begin
          if (count == CW'(CLKS_PER_BIT - 1)) begin
            count          <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            count <= count + CW'(1);
          end
        end

        STOP: begin
          if (count == CW'(CLKS_PER_BIT - 1)) begin
            count <= '0;
            if (rx_s) begin
              rx_data <= shift;
              irr     <= 1'b1;
              overrun <= irr & ~bus.ack;
              state   <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end else begin
            count <= count + CW'(1);
          end
        end

        WAIT_HIGH: begin
          count <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_intr.sv
// Self-checking bench for uart_rx_intr: directed scenarios followed by
// random frames, all compared against a frame-level reference model.
module tb_uart_rx_intr;

  localparam int CPB     = 16;
  localparam int HALF    = CPB / 2;
  localparam int LATENCY = 3 + HALF + 9 * CPB;

  logic clk = 1'b0;
  logic reset;

  uart_rx_intr_if bus ();

  uart_rx_intr #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int frame_start = 0;

  int ferr_seen = 0;
  int ovr_seen  = 0;
  int both_seen = 0;

  logic [7:0] m_data;
  logic       m_irr;
  int         m_ferr;
  int         m_ovr;

  // Free-running cycle counter for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Count event pulses away from the active edge
  always @(negedge clk) begin
    if (bus.frame_err) ferr_seen++;
    if (bus.overrun) ovr_seen++;
    if (bus.frame_err && bus.overrun) both_seen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one 8N1 frame; starts and ends on a falling clock edge, leaves rx at the stop level
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
    bus.rx = 1'b0;
    frame_start = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.rx = data[i];
      repeat (CPB) @(negedge clk);
    end
    bus.rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  // Reference model: effect of one complete frame on the CPU-visible state
  task automatic modelFrame(input logic [7:0] data, input logic stop_bit, input logic ack_at_done);
    if (stop_bit) begin
      if (m_irr && !ack_at_done) m_ovr++;
      m_data = data;
      m_irr  = 1'b1;
    end else begin
      m_ferr++;
    end
  endtask

  task automatic applyAck(input int n);
    bus.ack = 1'b1;
    repeat (n) @(negedge clk);
    bus.ack = 1'b0;
    if (n > 0) m_irr = 1'b0;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_data"}, {24'h0, bus.rx_data}, {24'h0, m_data});
    checkOutput({tag, "_irr"}, {31'h0, bus.irr}, {31'h0, m_irr});
    checkOutput({tag, "_ferr"}, ferr_seen, m_ferr);
    checkOutput({tag, "_ovr"}, ovr_seen, m_ovr);
  endtask

  initial begin
    int rise;
    logic prev_bad;

    bus.rx  = 1'b1;
    bus.ack = 1'b0;
    reset   = 1'b1;
    m_data  = 8'h00;
    m_irr   = 1'b0;
    m_ferr  = 0;
    m_ovr   = 0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkState("reset");

    // Basic frame with measured latency, then a two-cycle ack
    rise = -1;
    fork
      applyStimulus(8'hA5, 1'b1);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (bus.irr) begin
            rise = cyc - frame_start;
            break;
          end
        end
      end
    join
    modelFrame(8'hA5, 1'b1, 1'b0);
    checkOutput("a5_latency", rise, LATENCY);
    checkState("a5");
    bus.ack = 1'b1;
    @(negedge clk);
    checkOutput("ack_first_cycle_irr", {31'h0, bus.irr}, 32'h0);
    @(negedge clk);
    bus.ack = 1'b0;
    m_irr = 1'b0;
    checkState("a5_acked");

    // Short low glitch must be rejected
    bus.rx = 1'b0;
    repeat (8) @(negedge clk);
    bus.rx = 1'b1;
    repeat (40) @(negedge clk);
    checkState("glitch");
    applyStimulus(8'h3C, 1'b1);
    modelFrame(8'h3C, 1'b1, 1'b0);
    checkState("3c");
    applyAck(1);

    // Framing error followed by a break, then recovery
    applyStimulus(8'h55, 1'b0);
    modelFrame(8'h55, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    checkState("break_low");
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    checkState("break_high");
    applyStimulus(8'h0F, 1'b1);
    modelFrame(8'h0F, 1'b1, 1'b0);
    checkState("0f");
    applyAck(1);

    // Back-to-back frames without ack cause an overrun
    applyStimulus(8'h11, 1'b1);
    modelFrame(8'h11, 1'b1, 1'b0);
    checkState("b2b_11");
    applyStimulus(8'h22, 1'b1);
    modelFrame(8'h22, 1'b1, 1'b0);
    bus.rx = 1'b1;
    checkState("b2b_22");

    // Ack coinciding with completion: set wins, no overrun
    repeat (5) @(negedge clk);
    fork
      applyStimulus(8'h7E, 1'b1);
      begin
        for (int i = 0; i < 400; i++) begin
          @(negedge clk);
          if (cyc == frame_start + LATENCY - 1) begin
            bus.ack = 1'b1;
            @(negedge clk);
            bus.ack = 1'b0;
            break;
          end
        end
      end
    join
    modelFrame(8'h7E, 1'b1, 1'b1);
    checkState("ack_on_done");

    // Reset in the middle of a frame aborts it silently
    fork
      applyStimulus(8'hFF, 1'b1);
      begin
        repeat (60) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
    join
    m_irr  = 1'b0;
    m_data = 8'h00;
    repeat (10) @(negedge clk);
    checkState("mid_reset");
    applyStimulus(8'h81, 1'b1);
    modelFrame(8'h81, 1'b1, 1'b0);
    checkState("81");

    // Random frames, gaps, acks and stop-bit errors
    prev_bad = 1'b0;
    for (int n = 0; n < 20; n++) begin
      logic [7:0] data;
      logic       stop_bit;
      int         gap;
      data     = 8'($urandom);
      stop_bit = ($urandom_range(0, 3) != 0);
      gap      = $urandom_range(0, 12);
      if (prev_bad && gap < 4) gap = 4;
      bus.rx = 1'b1;
      if ($urandom_range(0, 2) == 0) applyAck(1);
      repeat (gap) @(negedge clk);
      applyStimulus(data, stop_bit);
      modelFrame(data, stop_bit, 1'b0);
      checkState($sformatf("rand%0d", n));
      prev_bad = !stop_bit;
    end
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);

    checkOutput("ferr_ovr_same_cycle", both_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
